planificador_riego: RTL

PLANIFICADOR_RIEGO -- requirements
Module: planificador_riego

---
 rtl/planificador_riego.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/planificador_riego.sv
// Irrigation scheduler: round-robin grants of pump, faucet and light from humidity/time packets.
// Defining PLANIFICADOR_WATCHDOG_EN adds a no-packet watchdog that aborts activity and flags error.
module planificador_riego #(
   parameter int unsigned T_BOMBA     = 50000000,
   parameter int unsigned T_GRIFO     = 50000000,
   parameter int unsigned T_LUZ       = 50000000,
   parameter int unsigned T_PAUSA     = 1000000,
   parameter int unsigned UMBRAL_BASE = 1000,
   parameter int unsigned UMBRAL_PASO = 100,
   parameter int unsigned MARGEN      = 400,
   parameter int unsigned HORA_ON     = 6,
   parameter int unsigned HORA_OFF    = 18,
   parameter int unsigned T_WDT       = 500000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        listo,
   input  logic [11:0] humedad,
   input  logic [15:0] hora,
   input  logic [3:0]  tipoPlanta,
   input  logic        MODbomba,
   input  logic        MODgrifo,
   input  logic        MODluz,
   output logic        activarB,
   output logic        activarG,
   output logic        activarL,
   output logic        ocupado,
   output logic        error
);

   typedef enum logic [1:0] {IDLE, EVAL, RUN, PAUSA} estado_t;

   // Enables are registered one cycle behind RUN, so the EVAL cycle closes the all-off gap
   // and PAUSA itself lasts one cycle less than T_PAUSA.
   localparam int unsigned CICLOS_PAUSA = (T_PAUSA > 1) ? T_PAUSA - 1 : 1;

   estado_t     estado_q, estado_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  req_q, req_d;
   logic [1:0]  ptr_q, ptr_d, grant_q, grant_d;
   logic        pend_v_q, pend_v_d;
   logic [11:0] pend_hum_q, pend_hum_d;
   logic [7:0]  pend_hora_q, pend_hora_d;
   logic [3:0]  pend_tipo_q, pend_tipo_d;
   logic        error_q, error_d;
   logic [2:0]  act_q, act_d;
   logic        ocupado_q, ocupado_d;
   logic [2:0]  mods, req_eval;
   logic        hay_req;
   logic [1:0]  sel;
   logic [2:0]  rr_idx;
   logic [31:0] t_run;
   logic        wdt_fire;
   logic [7:0]  unused_minuto;

   function automatic logic [2:0] calc_req(input logic [11:0] hum, input logic [7:0] hh,
                                           input logic [3:0] tipo, input logic [2:0] m);
      logic [31:0] umb;
      logic [31:0] umb_g;
      logic [2:0]  r;
      umb = UMBRAL_BASE + 32'(tipo) * UMBRAL_PASO;
      if (umb > 32'd4095) umb = 32'd4095;
      umb_g = (umb > MARGEN) ? umb - MARGEN : '0;
      r[0] = m[0] && (32'(hum) < umb);
      r[1] = m[1] && (umb_g != '0) && (32'(hum) < umb_g);
      r[2] = m[2] && (hh <= 8'd23) && (32'(hh) >= HORA_ON) && (32'(hh) < HORA_OFF);
      return r;
   endfunction

   assign mods          = {MODluz, MODgrifo, MODbomba};
   assign unused_minuto = hora[7:0];
   // A pending packet replaces whatever requests remain from the previous one.
   assign req_eval      = pend_v_q ? calc_req(pend_hum_q, pend_hora_q, pend_tipo_q, mods) : req_q;

   always_comb begin
      hay_req = 1'b0;
      sel     = ptr_q;
      rr_idx  = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         rr_idx = {1'b0, ptr_q} + 3'(i);
         if (rr_idx >= 3'd3) rr_idx = rr_idx - 3'd3;
         if (!hay_req && req_eval[rr_idx[1:0]]) begin
            hay_req = 1'b1;
            sel     = rr_idx[1:0];
         end
      end
   end

   always_comb begin
      case (grant_q)
         2'd0:    t_run = T_BOMBA;
         2'd1:    t_run = T_GRIFO;
         default: t_run = T_LUZ;
      endcase
   end

`ifdef PLANIFICADOR_WATCHDOG_EN
   logic [31:0] wdt_q, wdt_d;
   always_comb begin
      wdt_fire = !listo && (wdt_q == T_WDT - 1);
      if (listo)               wdt_d = '0;
      else if (wdt_q >= T_WDT) wdt_d = wdt_q;
      else                     wdt_d = wdt_q + 1;
   end
`else
   localparam int unsigned unused_t_wdt = T_WDT;
   assign wdt_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         estado_q    <= IDLE;
         cnt_q       <= '0;
         req_q       <= '0;
         ptr_q       <= '0;
         grant_q     <= '0;
         pend_v_q    <= 1'b0;
         pend_hum_q  <= '0;
         pend_hora_q <= '0;
         pend_tipo_q <= '0;
         error_q     <= 1'b0;
         act_q       <= '0;
         ocupado_q   <= 1'b0;
`ifdef PLANIFICADOR_WATCHDOG_EN
         wdt_q       <= '0;
`endif
      end else begin
         estado_q    <= estado_d;
         cnt_q       <= cnt_d;
         req_q       <= req_d;
         ptr_q       <= ptr_d;
         grant_q     <= grant_d;
         pend_v_q    <= pend_v_d;
         pend_hum_q  <= pend_hum_d;
         pend_hora_q <= pend_hora_d;
         pend_tipo_q <= pend_tipo_d;
         error_q     <= error_d;
         act_q       <= act_d;
         ocupado_q   <= ocupado_d;
`ifdef PLANIFICADOR_WATCHDOG_EN
         wdt_q       <= wdt_d;
`endif
      end
   end

   always_comb begin
      estado_d    = estado_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      ptr_d       = ptr_q;
      grant_d     = grant_q;
      pend_v_d    = pend_v_q;
      pend_hum_d  = pend_hum_q;
      pend_hora_d = pend_hora_q;
      pend_tipo_d = pend_tipo_q;
      error_d     = error_q;
      case (estado_q)
         IDLE: if (listo) estado_d = EVAL;
         EVAL: begin
            pend_v_d = 1'b0;
            req_d    = req_eval;
            cnt_d    = '0;
            if (hay_req) begin
               grant_d  = sel;
               estado_d = RUN;
            end else begin
               estado_d = IDLE;
            end
         end
         RUN: begin
            if (!mods[grant_q] || cnt_q == t_run - 1) begin
               estado_d       = PAUSA;
               cnt_d          = '0;
               req_d[grant_q] = 1'b0;
               ptr_d          = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;
            end else begin
               cnt_d = cnt_q + 1;
            end
         end
         default: begin
            if (cnt_q == CICLOS_PAUSA - 1) begin
               estado_d = EVAL;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1;
            end
         end
      endcase
      if (listo) begin
         pend_v_d    = 1'b1;
         pend_hum_d  = humedad;
         pend_hora_d = hora[15:8];
         pend_tipo_d = tipoPlanta;
         error_d     = (hora[15:8] > 8'd23);
      end
      if (wdt_fire) begin
         estado_d = IDLE;
         cnt_d    = '0;
         req_d    = '0;
         pend_v_d = 1'b0;
         error_d  = 1'b1;
      end
   end

   always_comb begin
      act_d = '0;
      if (estado_q == RUN && mods[grant_q] && !wdt_fire) act_d[grant_q] = 1'b1;
      ocupado_d = (estado_d != IDLE);
   end

   assign activarB = act_q[0];
   assign activarG = act_q[1];
   assign activarL = act_q[2];
   assign ocupado  = ocupado_q;
   assign error    = error_q;

endmodule
